// File: rtl/capture_sequencer.sv
// capture_sequencer: arm, circular pre-trigger capture, post-trigger countdown and oldest-first
// valid/ready readout for one 8Kx8 sample BRAM. Optional macro CAPTURE_PRETRIG_FULL_EN.
module capture_sequencer #(
    parameter int DEPTH_LOG2 = 13,
    parameter int WIDTH      = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ARM,
    input  logic                  ABORT,
    input  logic [DEPTH_LOG2-1:0] POST_COUNT,
    input  logic                  SAMPLE_VALID,
    input  logic [WIDTH-1:0]      SAMPLE,
    input  logic                  TRIGGER,
    input  logic                  READ_START,
    output logic [WIDTH-1:0]      RD_DATA,
    output logic                  RD_VALID,
    input  logic                  RD_READY,
    output logic                  RD_LAST,
    output logic                  RAM_EN,
    output logic                  RAM_WE,
    output logic [DEPTH_LOG2-1:0] RAM_ADDR,
    output logic [WIDTH-1:0]      RAM_DIN,
    input  logic [WIDTH-1:0]      RAM_DOUT,
    output logic [2:0]            STATE,
    output logic                  WRAPPED,
    output logic [DEPTH_LOG2-1:0] TRIG_ADDR
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_POST  = 3'd2,
        S_DONE  = 3'd3,
        S_READ  = 3'd4
    } state_t;

    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] ONE_LEFT   = (DEPTH_LOG2+1)'(1);

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wptr_q;
    logic                  wrapped_q;
    logic [DEPTH_LOG2-1:0] trig_addr_q;
    logic [DEPTH_LOG2-1:0] post_lat_q;
    logic [DEPTH_LOG2-1:0] remaining_q;
    logic [DEPTH_LOG2-1:0] rd_addr_q;
    logic [DEPTH_LOG2:0]   rd_left_q;

    logic [1:0]            fifo_cnt_q;
    logic [WIDTH-1:0]      slot0_data_q, slot1_data_q;
    logic                  slot0_last_q, slot1_last_q;
    logic                  inflight_q, inflight_last_q;

    logic                  wr_en, issue, trig_hit, arm_go, read_go;
    logic                  trig_allow, pop, push;
    logic [2:0]            occ_after_pop;

`ifdef CAPTURE_PRETRIG_FULL_EN
    assign trig_allow = wrapped_q;
`else
    assign trig_allow = 1'b1;
`endif

    assign RD_VALID  = (fifo_cnt_q != 2'd0);
    assign RD_DATA   = slot0_data_q;
    assign RD_LAST   = RD_VALID && slot0_last_q;
    assign STATE     = state_q;
    assign WRAPPED   = wrapped_q;
    assign TRIG_ADDR = trig_addr_q;

    assign pop  = RD_VALID && RD_READY;
    assign push = inflight_q;
    // Reads are issued only when a skid slot is guaranteed for the returning byte.
    assign occ_after_pop = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_en    = 1'b0;
        issue    = 1'b0;
        trig_hit = 1'b0;
        arm_go   = 1'b0;
        read_go  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ARM) begin
                    arm_go  = 1'b1;
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                wr_en = SAMPLE_VALID;
                if (SAMPLE_VALID && TRIGGER && trig_allow) begin
                    trig_hit = 1'b1;
                    state_d  = (post_lat_q == '0) ? S_DONE : S_POST;
                end
            end
            S_POST: begin
                wr_en = SAMPLE_VALID;
                if (SAMPLE_VALID && remaining_q == DEPTH_LOG2'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (ARM) begin
                    arm_go  = 1'b1;
                    state_d = S_ARMED;
                end else if (READ_START) begin
                    read_go = 1'b1;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                issue = (rd_left_q != '0) && (occ_after_pop < 3'd2);
                if (pop && slot0_last_q) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (ABORT) begin
            state_d  = S_IDLE;
            wr_en    = 1'b0;
            issue    = 1'b0;
            trig_hit = 1'b0;
            arm_go   = 1'b0;
            read_go  = 1'b0;
        end
    end

    always_comb begin
        RAM_EN   = wr_en || issue;
        RAM_WE   = wr_en;
        RAM_ADDR = issue ? rd_addr_q : wptr_q;
        RAM_DIN  = wr_en ? SAMPLE : '0;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wptr_q      <= '0;
            wrapped_q   <= 1'b0;
            trig_addr_q <= '0;
            post_lat_q  <= '0;
            remaining_q <= '0;
        end else begin
            if (arm_go) begin
                wptr_q     <= '0;
                wrapped_q  <= 1'b0;
                post_lat_q <= POST_COUNT;
            end else if (wr_en) begin
                wptr_q <= wptr_q + 1'b1;
                if (wptr_q == '1) begin
                    wrapped_q <= 1'b1;
                end
            end
            if (trig_hit) begin
                trig_addr_q <= wptr_q;
                remaining_q <= post_lat_q;
            end else if (wr_en && state_q == S_POST) begin
                remaining_q <= remaining_q - 1'b1;
            end
        end
    end

    // Oldest sample sits at WPTR once the buffer has wrapped, otherwise at address 0.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_addr_q <= '0;
            rd_left_q <= '0;
        end else if (read_go) begin
            rd_addr_q <= wrapped_q ? wptr_q : '0;
            rd_left_q <= wrapped_q ? FULL_COUNT : {1'b0, wptr_q};
        end else if (issue) begin
            rd_addr_q <= rd_addr_q + 1'b1;
            rd_left_q <= rd_left_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fifo_cnt_q      <= '0;
            slot0_data_q    <= '0;
            slot1_data_q    <= '0;
            slot0_last_q    <= 1'b0;
            slot1_last_q    <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else if (ABORT) begin
            fifo_cnt_q      <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q      <= issue;
            inflight_last_q <= issue && (rd_left_q == ONE_LEFT);
            case ({push, pop})
                2'b10: begin
                    if (fifo_cnt_q == 2'd0) begin
                        slot0_data_q <= RAM_DOUT;
                        slot0_last_q <= inflight_last_q;
                    end else begin
                        slot1_data_q <= RAM_DOUT;
                        slot1_last_q <= inflight_last_q;
                    end
                    fifo_cnt_q <= fifo_cnt_q + 2'd1;
                end
                2'b01: begin
                    slot0_data_q <= slot1_data_q;
                    slot0_last_q <= slot1_last_q;
                    fifo_cnt_q   <= fifo_cnt_q - 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt_q == 2'd1) begin
                        slot0_data_q <= RAM_DOUT;
                        slot0_last_q <= inflight_last_q;
                    end else begin
                        slot0_data_q <= slot1_data_q;
                        slot0_last_q <= slot1_last_q;
                        slot1_data_q <= RAM_DOUT;
                        slot1_last_q <= inflight_last_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer with a behavioural 8Kx8 BRAM attached to the RAM_* port.
module tb_capture_sequencer;

    logic        CLK, RESET, ARM, ABORT, SAMPLE_VALID, TRIGGER, READ_START, RD_READY;
    logic [12:0] POST_COUNT;
    logic [7:0]  SAMPLE, RD_DATA, RAM_DIN, RAM_DOUT;
    logic        RD_VALID, RD_LAST, RAM_EN, RAM_WE, WRAPPED;
    logic [12:0] RAM_ADDR, TRIG_ADDR;
    logic [2:0]  STATE;

    int errors = 0;
    int checks = 0;
    logic [7:0] mem [0:8191];

    capture_sequencer #(.DEPTH_LOG2(13), .WIDTH(8)) dut (
        .CLK(CLK), .RESET(RESET), .ARM(ARM), .ABORT(ABORT), .POST_COUNT(POST_COUNT),
        .SAMPLE_VALID(SAMPLE_VALID), .SAMPLE(SAMPLE), .TRIGGER(TRIGGER),
        .READ_START(READ_START), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
        .RD_READY(RD_READY), .RD_LAST(RD_LAST), .RAM_EN(RAM_EN), .RAM_WE(RAM_WE),
        .RAM_ADDR(RAM_ADDR), .RAM_DIN(RAM_DIN), .RAM_DOUT(RAM_DOUT), .STATE(STATE),
        .WRAPPED(WRAPPED), .TRIG_ADDR(TRIG_ADDR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) begin
        if (RAM_EN) begin
            if (RAM_WE) mem[RAM_ADDR] <= RAM_DIN;
            else        RAM_DOUT <= mem[RAM_ADDR];
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic arm(input int post);
        ARM = 1'b1;
        POST_COUNT = 13'(post);
        step();
        ARM = 1'b0;
    endtask

    task automatic feed(input int base, input int n, input int trig_a, input bit chk);
        for (int i = 0; i < n; i++) begin
            SAMPLE_VALID = 1'b1;
            SAMPLE = 8'((base + i) & 255);
            TRIGGER = ((base + i) == trig_a);
            if (chk) begin
                #1;
                check("wr_en", RAM_EN, 1);
                check("wr_we", RAM_WE, 1);
                check("wr_addr", RAM_ADDR, 32'((base + i) % 8192));
                check("wr_din", RAM_DIN, 32'((base + i) & 255));
            end
            step();
        end
        SAMPLE_VALID = 1'b0;
        TRIGGER = 1'b0;
    endtask

    task automatic read_run(input int first, input int n, input bit toggle);
        int got = 0;
        int cyc = 0;
        int limit = 3 * n + 20;
        bit held = 1'b0;
        logic [7:0] held_data = '0;
        READ_START = 1'b1;
        step();
        READ_START = 1'b0;
        check("read_state", STATE, 3'd4);
        while (got < n && cyc < limit) begin
            RD_READY = toggle ? (cyc % 2 == 1) : 1'b1;
            if (cyc < 2) check("rd_latency", RD_VALID, 0);
            if (cyc == 2) check("rd_first_valid", RD_VALID, 1);
            if (held) begin
                check("rd_hold_valid", RD_VALID, 1);
                check("rd_hold_data", RD_DATA, held_data);
            end
            held = RD_VALID && !RD_READY;
            held_data = RD_DATA;
            if (RD_VALID && RD_READY) begin
                check("rd_data", RD_DATA, 32'((first + got) & 255));
                check("rd_last", RD_LAST, (got == n - 1));
                got++;
            end
            step();
            cyc++;
        end
        RD_READY = 1'b0;
        check("rd_count", got, n);
        if (!toggle) check("rd_cycles", cyc, n + 2);
        check("rd_done_state", STATE, 3'd3);
        check("rd_valid_after", RD_VALID, 0);
    endtask

    initial begin
        RESET = 1'b1; ARM = 1'b0; ABORT = 1'b0; POST_COUNT = '0; SAMPLE_VALID = 1'b0;
        SAMPLE = '0; TRIGGER = 1'b0; READ_START = 1'b0; RD_READY = 1'b0;
        step();
        step();
        check("rst_state", STATE, 0);
        check("rst_wrapped", WRAPPED, 0);
        check("rst_trig_addr", TRIG_ADDR, 0);
        check("rst_rd_valid", RD_VALID, 0);
        check("rst_rd_last", RD_LAST, 0);
        check("rst_rd_data", RD_DATA, 0);
        check("rst_ram_en", RAM_EN, 0);
        check("rst_ram_we", RAM_WE, 0);
        RESET = 1'b0;
        step();

`ifndef CAPTURE_PRETRIG_FULL_EN
        // POST=3, trigger on 0x05: 0x06..0x08 stored after it
        arm(3);
        check("t1_armed", STATE, 1);
        feed(0, 8, 5, 1'b1);
        check("t1_post", STATE, 2);
        feed(8, 1, -1, 1'b1);
        check("t1_done", STATE, 3);
        SAMPLE_VALID = 1'b1; SAMPLE = 8'h09;
        #1;
        check("t1_frozen_en", RAM_EN, 0);
        step();
        SAMPLE_VALID = 1'b0;
        check("t1_trig_addr", TRIG_ADDR, 5);
        check("t1_wrapped", WRAPPED, 0);
        read_run(0, 9, 1'b0);
        read_run(0, 9, 1'b1);

        // abort one cycle into READ while a read is being issued
        READ_START = 1'b1;
        step();
        READ_START = 1'b0;
        step();
        ABORT = 1'b1;
        #1;
        check("abort_rd_ram_en", RAM_EN, 0);
        step();
        ABORT = 1'b0;
        check("abort_rd_state", STATE, 0);
        check("abort_rd_valid", RD_VALID, 0);
        step();
        check("abort_rd_valid2", RD_VALID, 0);

        READ_START = 1'b1;
        step();
        READ_START = 1'b0;
        check("idle_read_ignored", STATE, 0);

        arm(5);
        feed(0, 4, 2, 1'b0);
        check("t3_post", STATE, 2);
        ABORT = 1'b1; SAMPLE_VALID = 1'b1;
        #1;
        check("abort_post_ram_en", RAM_EN, 0);
        step();
        ABORT = 1'b0; SAMPLE_VALID = 1'b0;
        check("abort_post_state", STATE, 0);
        check("abort_post_rd_valid", RD_VALID, 0);

        // trigger on the very first sample, POST=0
        arm(0);
        feed(0, 1, 0, 1'b1);
        check("t5_done", STATE, 3);
        check("t5_trig_addr", TRIG_ADDR, 0);
        read_run(0, 1, 1'b0);

        // ARM wins over READ_START in DONE
        ARM = 1'b1; READ_START = 1'b1; POST_COUNT = '0;
        step();
        ARM = 1'b0; READ_START = 1'b0;
        check("arm_wins", STATE, 1);

        feed(0, 8200, 8199, 1'b0);
        check("wrap_done", STATE, 3);
        check("wrap_wrapped", WRAPPED, 1);
        check("wrap_trig_addr", TRIG_ADDR, 7);
        read_run(8, 8192, 1'b0);
`else
        arm(0);
        feed(0, 101, 100, 1'b0);
        check("pf_early_ignored", STATE, 1);
        check("pf_not_wrapped", WRAPPED, 0);
        feed(101, 8200, 8300, 1'b0);
        check("pf_done", STATE, 3);
        check("pf_wrapped", WRAPPED, 1);
        check("pf_trig_addr", TRIG_ADDR, 108);
        read_run(109, 8192, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
